axi_reg_responder: RTL

AXI_REG_RESPONDER -- requirements
Module: axi_reg_responder

---
 rtl/axi_reg_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axi_reg_responder.sv
// AXI4-Lite slave that bridges single-beat transactions onto a paged register bus.
// One transaction in flight at a time; only full-word writes reach the registers.
module axi_reg_responder #(
    parameter int unsigned PAGE_NUM   = 5,
    parameter int unsigned PAGE_AW    = 10,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [31:0]              s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [2**PAGE_NUM-1:0]   mem_cs_o,
    output logic [PAGE_AW-1:0]       mem_addr_o,
    output logic [31:0]              mem_dat_o,
    output logic                     mem_wstb_o,
    output logic                     mem_rstb_o,
    input  logic [31:0]              mem_dat_i
);

    localparam int unsigned NumPages = 2**PAGE_NUM;
    localparam int unsigned PageLsb  = PAGE_AW + 2;
    localparam int unsigned PageMsb  = PAGE_AW + PAGE_NUM + 1;
    localparam logic [2:0]  RdLat    = 3'(RD_LATENCY);
    localparam logic [1:0]  RespOkay = 2'b00;
    localparam logic [1:0]  RespSlv  = 2'b10;

    typedef enum logic [1:0] {StIdle, StWresp, StRwait, StRdata} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [NumPages-1:0]   cs_q, cs_d;
    logic [PAGE_AW-1:0]    addr_q, addr_d;
    logic [31:0]           dat_q, dat_d;
    logic                  wstb_q, wstb_d;
    logic                  rstb_q, rstb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  idle;
    logic                  wr_hs;
    logic                  rd_hs;
    logic [PAGE_NUM-1:0]   wr_page, rd_page;
    logic [PAGE_AW-1:0]    wr_word, rd_word;
    logic [NumPages-1:0]   wr_cs, rd_cs;
    logic                  unused_addr_bits;

    assign wr_page = s_axi_awaddr[PageMsb:PageLsb];
    assign rd_page = s_axi_araddr[PageMsb:PageLsb];
    assign wr_word = s_axi_awaddr[PageLsb-1:2];
    assign rd_word = s_axi_araddr[PageLsb-1:2];
    assign wr_cs   = NumPages'(1) << wr_page;
    assign rd_cs   = NumPages'(1) << rd_page;

    // Bits above the page field alias, so the page index wraps.
    assign unused_addr_bits = ^{s_axi_awaddr[31:PageMsb+1], s_axi_awaddr[1:0],
                                s_axi_araddr[31:PageMsb+1], s_axi_araddr[1:0]};

    // Write pair wins over a simultaneous read; the read waits for the next idle cycle.
    assign idle          = (state_q == StIdle) && !reset_i;
    assign wr_hs         = idle && s_axi_awvalid && s_axi_wvalid;
    assign rd_hs         = idle && s_axi_arvalid && !(s_axi_awvalid && s_axi_wvalid);
    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign s_axi_arready = rd_hs;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_d     = cs_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        wstb_d   = 1'b0;
        rstb_d   = 1'b0;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (wr_hs) begin
                    state_d  = StWresp;
                    addr_d   = wr_word;
                    dat_d    = s_axi_wdata;
                    bvalid_d = 1'b1;
                    if (s_axi_wstrb == 4'hF) begin
                        cs_d    = wr_cs;
                        wstb_d  = 1'b1;
                        bresp_d = RespOkay;
                    end else begin
                        bresp_d = RespSlv;
                    end
                end else if (rd_hs) begin
                    state_d = StRwait;
                    cs_d    = rd_cs;
                    addr_d  = rd_word;
                    rstb_d  = 1'b1;
                    cnt_d   = 3'd0;
                end
            end
            StWresp: begin
                if (s_axi_bready) begin
                    state_d  = StIdle;
                    bvalid_d = 1'b0;
                    cs_d     = '0;
                end
            end
            StRwait: begin
                // cnt_q is 0 in the strobe cycle, so data is taken RD_LATENCY cycles later.
                if (cnt_q == RdLat) begin
                    state_d  = StRdata;
                    rdata_d  = mem_dat_i;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StRdata: begin
                if (s_axi_rready) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b0;
                    cs_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            cs_q     <= '0;
            addr_q   <= '0;
            dat_q    <= '0;
            wstb_q   <= 1'b0;
            rstb_q   <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            wstb_q   <= wstb_d;
            rstb_q   <= rstb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign mem_cs_o     = cs_q;
    assign mem_addr_o   = addr_q;
    assign mem_dat_o    = dat_q;
    assign mem_wstb_o   = wstb_q;
    assign mem_rstb_o   = rstb_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = RespOkay;

endmodule
